// File: rtl/cr16_regfile_pkg.sv
// Shared types and helpers for the CR16 register-file read side.
// Holds the reader FSM encoding, the address-width helper and the forwarding mux.
package cr16_regfile_pkg;

    typedef enum logic {
        IDLE,
        DUMP
    } state_e;

    localparam int FWD_MAX_W = 64;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A register written this cycle reads back its new value.
    function automatic logic [FWD_MAX_W-1:0] fwd_read(
        input logic                 wr_en,
        input logic [FWD_MAX_W-1:0] wr_data,
        input logic [FWD_MAX_W-1:0] cur_data
    );
        return wr_en ? wr_data : cur_data;
    endfunction

endpackage

// File: rtl/regfile_reader.sv
// Operand read port for the CR16 register file with write forwarding,
// a single-entry output slot and a debug dump mode on the same channel.
module regfile_reader
    import cr16_regfile_pkg::*;
#(
    parameter int P_REG_WIDTH  = 16,
    parameter int P_FILE_WIDTH = 16,
    localparam int AW = addr_width(P_FILE_WIDTH)
) (
    input  logic                   I_CLK,
    input  logic                   I_RESET,
    input  logic [P_REG_WIDTH-1:0] I_REG_DATA [P_FILE_WIDTH],
    input  logic [P_REG_WIDTH-1:0] I_REG_BUS,
    input  logic [P_FILE_WIDTH-1:0] I_REG_ENABLE,
    input  logic                   I_REQ_VALID,
    output logic                   O_REQ_READY,
    input  logic [AW-1:0]          I_ADDR_A,
    input  logic [AW-1:0]          I_ADDR_B,
    output logic                   O_RD_VALID,
    input  logic                   I_RD_READY,
    output logic [P_REG_WIDTH-1:0] O_DATA_A,
    output logic [P_REG_WIDTH-1:0] O_DATA_B,
    output logic                   O_RD_DUMP,
    input  logic                   I_DUMP_START,
    output logic                   O_DUMP_BUSY
);

    state_e                 state_q, state_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic                   valid_q, valid_d;
    logic                   dump_q, dump_d;
    logic [P_REG_WIDTH-1:0] data_a_q, data_a_d;
    logic [P_REG_WIDTH-1:0] data_b_q, data_b_d;
    logic                   slot_free;
    logic                   req_ready;

    function automatic logic [P_REG_WIDTH-1:0] fwd(input logic [AW-1:0] a);
        return P_REG_WIDTH'(fwd_read(I_REG_ENABLE[a],
                                     FWD_MAX_W'(I_REG_BUS),
                                     FWD_MAX_W'(I_REG_DATA[a])));
    endfunction

    // A consumed beat empties the slot unless something new loads behind it.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        valid_d   = valid_q && !I_RD_READY;
        dump_d    = dump_q;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        req_ready = 1'b0;
        slot_free = !valid_q || I_RD_READY;

        case (state_q)
            IDLE: begin
                if (I_DUMP_START) begin
                    state_d = DUMP;
                    idx_d   = '0;
                end else begin
                    req_ready = slot_free && !I_RESET;
                    if (I_REQ_VALID && slot_free) begin
                        valid_d  = 1'b1;
                        data_a_d = fwd(I_ADDR_A);
                        data_b_d = fwd(I_ADDR_B);
                        dump_d   = 1'b0;
                    end
                end
            end
            DUMP: begin
                if (slot_free) begin
                    valid_d  = 1'b1;
                    data_a_d = fwd(idx_q);
                    data_b_d = P_REG_WIDTH'(idx_q);
                    dump_d   = 1'b1;
                    idx_d    = idx_q + 1'b1;
                    if (idx_q == AW'(P_FILE_WIDTH - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            dump_q   <= 1'b0;
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            dump_q   <= dump_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    assign O_REQ_READY = req_ready;
    assign O_RD_VALID  = valid_q;
    assign O_DATA_A    = data_a_q;
    assign O_DATA_B    = data_b_q;
    assign O_RD_DUMP   = dump_q;
    assign O_DUMP_BUSY = (state_q == DUMP);

endmodule

// File: tb/tb_regfile_reader.sv
// Randomized and directed bench for regfile_reader against a cycle-level
// behavioural model of the slot, dump sequence and register file contents.
module tb_regfile_reader;

    localparam int RW = 16;
    localparam int FW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] regs [FW];
    logic [RW-1:0] bus;
    logic [FW-1:0] enable;
    logic          reqValid;
    logic          reqReady;
    logic [AW-1:0] addrA;
    logic [AW-1:0] addrB;
    logic          rdValid;
    logic          rdReady;
    logic [RW-1:0] dataA;
    logic [RW-1:0] dataB;
    logic          rdDump;
    logic          dumpStart;
    logic          dumpBusy;

    int checks = 0;
    int errors = 0;

    logic          mValid;
    logic          mDump;
    logic          mDumping;
    logic [RW-1:0] mA;
    logic [RW-1:0] mB;
    int            mIdx;

    always #5 clk = ~clk;

    regfile_reader #(
        .P_REG_WIDTH (RW),
        .P_FILE_WIDTH(FW)
    ) dut (
        .I_CLK       (clk),
        .I_RESET     (reset),
        .I_REG_DATA  (regs),
        .I_REG_BUS   (bus),
        .I_REG_ENABLE(enable),
        .I_REQ_VALID (reqValid),
        .O_REQ_READY (reqReady),
        .I_ADDR_A    (addrA),
        .I_ADDR_B    (addrB),
        .O_RD_VALID  (rdValid),
        .I_RD_READY  (rdReady),
        .O_DATA_A    (dataA),
        .O_DATA_B    (dataB),
        .O_RD_DUMP   (rdDump),
        .I_DUMP_START(dumpStart),
        .O_DUMP_BUSY (dumpBusy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [RW-1:0] fwdModel(input int a);
        return enable[a] ? bus : regs[a];
    endfunction

    // One clock cycle: inputs are already driven; check ready, advance the model, check registered outputs.
    task automatic applyStimulus();
        logic          expReady;
        logic          free;
        logic          nValid;
        logic          nDump;
        logic          nDumping;
        logic [RW-1:0] nA;
        logic [RW-1:0] nB;
        int            nIdx;
        logic [RW-1:0] nRegs [FW];

        #1;
        free     = !mValid || rdReady;
        expReady = !reset && !mDumping && !dumpStart && free;
        checkOutput("req_ready", 32'(reqReady), 32'(expReady));

        nValid   = mValid && !rdReady;
        nA       = mA;
        nB       = mB;
        nDump    = mDump;
        nDumping = mDumping;
        nIdx     = mIdx;
        if (reset) begin
            nValid   = 1'b0;
            nA       = '0;
            nB       = '0;
            nDump    = 1'b0;
            nDumping = 1'b0;
            nIdx     = 0;
        end else if (mDumping) begin
            if (free) begin
                nValid = 1'b1;
                nA     = fwdModel(mIdx);
                nB     = RW'(mIdx);
                nDump  = 1'b1;
                nIdx   = mIdx + 1;
                if (nIdx == FW) nDumping = 1'b0;
            end
        end else if (dumpStart) begin
            nDumping = 1'b1;
            nIdx     = 0;
        end else if (reqValid && free) begin
            nValid = 1'b1;
            nA     = fwdModel(int'(addrA));
            nB     = fwdModel(int'(addrB));
            nDump  = 1'b0;
        end
        for (int k = 0; k < FW; k++) nRegs[k] = enable[k] ? bus : regs[k];

        @(posedge clk);
        #1;
        mValid   = nValid;
        mA       = nA;
        mB       = nB;
        mDump    = nDump;
        mDumping = nDumping;
        mIdx     = nIdx;
        for (int k = 0; k < FW; k++) regs[k] = nRegs[k];

        @(negedge clk);
        checkOutput("rd_valid", 32'(rdValid), 32'(mValid));
        checkOutput("data_a", 32'(dataA), 32'(mA));
        checkOutput("data_b", 32'(dataB), 32'(mB));
        checkOutput("rd_dump", 32'(rdDump), 32'(mDump));
        checkOutput("dump_busy", 32'(dumpBusy), 32'(mDumping));
    endtask

    initial begin
        int  beats;
        int  pbeats;
        bit  gotReq;
        bit  sawSix;

        reset     = 1'b1;
        bus       = '0;
        enable    = '0;
        reqValid  = 1'b0;
        addrA     = '0;
        addrB     = '0;
        rdReady   = 1'b1;
        dumpStart = 1'b0;
        for (int k = 0; k < FW; k++) regs[k] = '0;
        mValid = 1'b0; mDump = 1'b0; mDumping = 1'b0; mA = '0; mB = '0; mIdx = 0;

        @(negedge clk);
        reqValid = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_valid", 32'(rdValid), 32'd0);
        checkOutput("reset_busy", 32'(dumpBusy), 32'd0);
        reset    = 1'b0;
        reqValid = 1'b0;
        applyStimulus();

        $display("[TB] basic read");
        regs[3]  = 16'h1234;
        regs[7]  = 16'hBEEF;
        reqValid = 1'b1;
        addrA    = 4'd3;
        addrB    = 4'd7;
        applyStimulus();
        checkOutput("basic_valid", 32'(rdValid), 32'd1);
        checkOutput("basic_a", 32'(dataA), 32'h1234);
        checkOutput("basic_b", 32'(dataB), 32'hBEEF);
        checkOutput("basic_dump", 32'(rdDump), 32'd0);

        $display("[TB] forwarding");
        regs[5] = 16'h0001;
        addrA   = 4'd5;
        addrB   = 4'd5;
        enable  = 16'h0020;
        bus     = 16'hCAFE;
        applyStimulus();
        checkOutput("fwd_a", 32'(dataA), 32'hCAFE);
        checkOutput("fwd_b", 32'(dataB), 32'hCAFE);
        enable = '0;

        $display("[TB] backpressure");
        rdReady = 1'b0;
        addrA   = 4'd3;
        addrB   = 4'd7;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("bp_ready", 32'(reqReady), 32'd0);
            applyStimulus();
            checkOutput("bp_hold_a", 32'(dataA), 32'hCAFE);
        end
        rdReady = 1'b1;
        #1;
        checkOutput("bp_release_ready", 32'(reqReady), 32'd1);
        applyStimulus();
        checkOutput("bp_release_a", 32'(dataA), 32'h1234);
        reqValid = 1'b0;

        $display("[TB] dump");
        for (int k = 0; k < FW; k++) regs[k] = RW'(32'h1000 + k);
        dumpStart = 1'b1;
        applyStimulus();
        dumpStart = 1'b0;
        beats = 0;
        for (int i = 0; i < 40 && beats < FW; i++) begin
            applyStimulus();
            if (i == 0) checkOutput("dump_first_beat", 32'(rdValid && rdDump), 32'd1);
            if (rdValid && rdDump) begin
                checkOutput("dump_idx", 32'(dataB), 32'(beats));
                checkOutput("dump_val", 32'(dataA), 32'h1000 + 32'(beats));
                beats++;
                if (beats == FW) checkOutput("dump_busy_end", 32'(dumpBusy), 32'd0);
            end
        end
        checkOutput("dump_beats", 32'(beats), 32'(FW));

        $display("[TB] dump priority");
        reqValid  = 1'b1;
        addrA     = 4'd2;
        addrB     = 4'd9;
        dumpStart = 1'b1;
        #1;
        checkOutput("prio_ready", 32'(reqReady), 32'd0);
        applyStimulus();
        dumpStart = 1'b0;
        pbeats = 0;
        gotReq = 1'b0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus();
            if (rdValid && rdDump) begin
                pbeats++;
            end else if (rdValid) begin
                gotReq = 1'b1;
                checkOutput("prio_req_a", 32'(dataA), 32'h1002);
                checkOutput("prio_req_b", 32'(dataB), 32'h1009);
                break;
            end
        end
        checkOutput("prio_beats", 32'(pbeats), 32'(FW));
        checkOutput("prio_req_seen", 32'(gotReq), 32'd1);
        reqValid = 1'b0;

        $display("[TB] reset mid-dump");
        dumpStart = 1'b1;
        applyStimulus();
        dumpStart = 1'b0;
        sawSix = 1'b0;
        for (int i = 0; i < 40 && !sawSix; i++) begin
            applyStimulus();
            if (rdValid && rdDump && dataB == 16'd6) sawSix = 1'b1;
        end
        checkOutput("mid_saw_beat6", 32'(sawSix), 32'd1);
        reset = 1'b1;
        applyStimulus();
        checkOutput("mid_reset_valid", 32'(rdValid), 32'd0);
        checkOutput("mid_reset_busy", 32'(dumpBusy), 32'd0);
        reset     = 1'b0;
        dumpStart = 1'b1;
        applyStimulus();
        dumpStart = 1'b0;
        applyStimulus();
        checkOutput("restart_idx", 32'(dataB), 32'd0);
        checkOutput("restart_dump", 32'(rdDump), 32'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 59) == 0);
            reqValid  = $urandom_range(0, 1) == 1;
            rdReady   = $urandom_range(0, 9) < 7;
            dumpStart = ($urandom_range(0, 29) == 0);
            addrA     = AW'($urandom_range(0, FW - 1));
            addrB     = AW'($urandom_range(0, FW - 1));
            bus       = RW'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    enable = '0;
                2:       enable = FW'(1) << $urandom_range(0, FW - 1);
                default: enable = FW'($urandom);
            endcase
            applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_reader.md
# regfile_reader

Read-side companion to the CR16 register file. Accepts operand-read requests for two register addresses over a valid/ready handshake and returns both values one cycle later from a single-entry output slot. Same-cycle writes to the file are forwarded. A debug dump mode streams every register out over the same output channel. Sits between the register-file data outputs and the decode/ALU operand latches, and also feeds the debug port.

## Interface
- P_REG_WIDTH, 16, width of each register
- P_FILE_WIDTH, 16, number of registers; power of two, ≥2
- Address width is AW = $clog2(P_FILE_WIDTH)

Ports:
- I_CLK  in  1  clock; all logic on rising edge
- I_RESET  in  1  synchronous, active-high reset
- I_REG_DATA  in  P_REG_WIDTH × P_FILE_WIDTH  current contents of all registers (unpacked array, index = register number)
- I_REG_BUS  in  P_REG_WIDTH  write data presented to the register file this cycle
- I_REG_ENABLE  in  P_FILE_WIDTH  per-register write enables presented to the register file this cycle
- I_REQ_VALID  in  1  read request valid
- O_REQ_READY  out  1  read request accepted when valid && ready
- I_ADDR_A, I_ADDR_B  in  AW  operand register numbers
- O_RD_VALID  out  1  output slot holds data
- I_RD_READY  in  1  consumer takes output when valid && ready
- O_DATA_A, O_DATA_B  out  P_REG_WIDTH  returned operands (in dump mode: register value / zero-extended index)
- O_RD_DUMP  out  1  current output beat is a dump beat
- I_DUMP_START  in  1  single-cycle dump request
- O_DUMP_BUSY  out  1  dump in progress

## Operation
- FSM states: IDLE, DUMP.
- Output slot: one entry, fields valid, data_a, data_b, dump. The slot is free when !valid || I_RD_READY.
- IDLE:
  - O_REQ_READY = slot free && !I_DUMP_START.
  - On accept, the slot loads fwd(I_ADDR_A) and fwd(I_ADDR_B) with dump = 0.
  - fwd(a) = I_REG_BUS if I_REG_ENABLE[a], else I_REG_DATA[a]. This returns the value the register holds after this edge.
- IDLE with I_DUMP_START: go to DUMP and clear the index counter to 0. The request is not accepted that cycle.
- DUMP:
  - O_REQ_READY = 0; O_DUMP_BUSY = 1.
  - Each cycle the slot is free, load data_a = fwd(idx), data_b = idx zero-extended, dump = 1, then idx++.
  - After loading idx = P_FILE_WIDTH−1, return to IDLE; the final beat may still be pending in the slot.
- I_DUMP_START in DUMP is ignored.
- If the slot is full and !I_RD_READY, nothing loads and the outputs hold stable.
- Both operands may address the same register; both get the same value.

## Timing
- Reset values: O_RD_VALID=0, O_DATA_A=0, O_DATA_B=0, O_RD_DUMP=0, O_DUMP_BUSY=0, state=IDLE, idx=0.
- O_REQ_READY is 0 while I_RESET is high.
- Reset mid-dump or with the slot full: everything returns to reset values on the next edge, and pending data is dropped.
- Latency: request accepted at edge n → O_RD_VALID=1 with data after edge n.
- Full throughput: with I_RD_READY held high, one request is accepted per cycle (back-to-back).
- O_REQ_READY depends combinationally on I_RD_READY and I_DUMP_START. O_DATA_* are registered.
- Dump length: P_FILE_WIDTH beats. With the consumer always ready, the first beat is visible 2 edges after the start edge, and O_DUMP_BUSY drops the cycle after the last beat loads.
- Write during a dump: a register written in the same cycle its index loads returns the new value. Earlier-loaded indices keep their old value.

## Structure
- Package cr16_regfile_pkg holds:
  - typedef enum {IDLE, DUMP} for the FSM
  - a localparam function for AW
  - function fwd_read (forwarding mux)
- No sub-module. The slot, FSM and counter live in one always_ff, and the next-state/ready logic in one always_comb.

## Test plan
- Basic read: after reset, R3=0x1234, R7=0xBEEF. Request A=3, B=7 with ready high → next cycle O_RD_VALID=1, A=0x1234, B=0xBEEF, O_RD_DUMP=0.
- Forwarding: request A=5 in the same cycle as I_REG_ENABLE=0x0020 and I_REG_BUS=0xCAFE, with R5 previously 0x0001 → returned A=0xCAFE.
- Backpressure: hold I_RD_READY=0 with the slot full → O_REQ_READY=0 and outputs unchanged for 5 cycles. Raise ready → the next request is accepted the same cycle.
- Dump: load Rk=0x1000+k, pulse I_DUMP_START, consumer always ready → 16 beats with B=0..15, A=0x1000..0x100F, O_RD_DUMP=1, O_REQ_READY=0 throughout, O_DUMP_BUSY low after the last load.
- Dump priority: I_DUMP_START and I_REQ_VALID in the same cycle → request not accepted, the dump runs, and the request is accepted after the final dump beat.
- Reset mid-dump: assert I_RESET after beat 6 → next cycle O_RD_VALID=0, O_DUMP_BUSY=0, and a new dump restarts at index 0.
